// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode seven-segment scanner with shadowed value, radix select,
// leading-zero blanking, per-digit decimal points and per-digit blink.
module seg7_scan_display #(
   parameter int NUM_DIGITS   = 8,
   parameter int SCAN_DIV     = 12500,
   parameter int GUARD        = 2,
   parameter int BLINK_FRAMES = 250
) (
   input  logic                    clock,
   input  logic                    resetN,
   input  logic                    enable,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    radix_octal,
   input  logic                    blank_lz,
   input  logic [NUM_DIGITS-1:0]   blink_mask,
   output logic [NUM_DIGITS-1:0]   an,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic                    pending,
   output logic                    frame_done
);

   localparam int VALUE_W = 4*NUM_DIGITS;
   localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] GUARD_C    = SW'(GUARD);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [SW-1:0]         slot;
   logic [IW-1:0]         idx;
   logic [BW-1:0]         bcnt;
   logic                  hidden;
   logic [VALUE_W-1:0]    shadow, disp;
   logic [NUM_DIGITS-1:0] sdp, ddp;

   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] zero, lzb;
   logic                  all_zero;
   logic [3:0]            cur_nib;
   logic                  cur_dp, cur_lzb, cur_blink, blanked;
   logic [NUM_DIGITS-1:0] an_p0;

   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: font = 7'h40;
         4'h1: font = 7'h79;
         4'h2: font = 7'h24;
         4'h3: font = 7'h30;
         4'h4: font = 7'h19;
         4'h5: font = 7'h12;
         4'h6: font = 7'h02;
         4'h7: font = 7'h78;
         4'h8: font = 7'h00;
         4'h9: font = 7'h10;
         4'hA: font = 7'h08;
         4'hB: font = 7'h03;
         4'hC: font = 7'h46;
         4'hD: font = 7'h21;
         4'hE: font = 7'h06;
         default: font = 7'h0E;
      endcase
   endfunction

   assign frame_done = (idx == IDX_LAST) && (slot == SLOT_LAST);

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         slot <= '0;
         idx  <= '0;
      end else if (slot == SLOT_LAST) begin
         slot <= '0;
         idx  <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
         slot <= slot + 1'b1;
      end
   end

   // Blink phase flips once every BLINK_FRAMES completed frames.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         bcnt   <= '0;
         hidden <= 1'b0;
      end else if (frame_done) begin
         if (bcnt == BLINK_LAST) begin
            bcnt   <= '0;
            hidden <= ~hidden;
         end else begin
            bcnt <= bcnt + 1'b1;
         end
      end
   end

   // Display only changes at the frame edge; a coincident load bypasses the shadow.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         shadow  <= '0;
         sdp     <= '0;
         disp    <= '0;
         ddp     <= '0;
         pending <= 1'b0;
      end else begin
         if (load) begin
            shadow <= value;
            sdp    <= dp_in;
         end
         if (frame_done) begin
            if (pending || load) begin
               disp <= load ? value : shadow;
               ddp  <= load ? dp_in : sdp;
            end
            pending <= 1'b0;
         end else if (load) begin
            pending <= 1'b1;
         end
      end
   end

   always_comb begin
      zero     = '0;
      lzb      = '0;
      all_zero = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         nib[i]  = radix_octal ? {1'b0, disp[3*i +: 3]} : disp[4*i +: 4];
         zero[i] = (nib[i] == 4'h0);
      end
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         all_zero = all_zero & zero[i];
         lzb[i]   = blank_lz && (i > 0) && all_zero;
      end
   end

   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_lzb   = 1'b0;
      cur_blink = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_nib   = nib[i];
            cur_dp    = ddp[i];
            cur_lzb   = lzb[i];
            cur_blink = blink_mask[i];
         end
      end
      blanked = cur_lzb || (hidden && cur_blink);
      an_p0   = '1;
      if (enable && (slot >= GUARD_C) && !blanked) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) an_p0[i] = 1'b0;
         end
      end
   end

   // Output register stage: one cycle behind the scan counters.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         an  <= '1;
         seg <= 7'h7F;
         dp  <= 1'b1;
      end else begin
         an  <= an_p0;
         seg <= blanked ? 7'h7F : font(cur_nib);
         dp  <= blanked ? 1'b1 : ~cur_dp;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed bench for seg7_scan_display: 4 digits, 4-cycle slots, 1-cycle guard, 2-frame blink.
module tb_seg7_scan_display;

   logic        clock = 1'b0;
   logic        resetN = 1'b0;
   logic        enable = 1'b0;
   logic        load = 1'b0;
   logic [15:0] value = '0;
   logic [3:0]  dp_in = '0;
   logic        radix_octal = 1'b0;
   logic        blank_lz = 1'b0;
   logic [3:0]  blink_mask = '0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        pending;
   logic        frame_done;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   seg7_scan_display #(
      .NUM_DIGITS(4), .SCAN_DIV(4), .GUARD(1), .BLINK_FRAMES(2)
   ) dut (
      .clock(clock), .resetN(resetN), .enable(enable), .load(load), .value(value),
      .dp_in(dp_in), .radix_octal(radix_octal), .blank_lz(blank_lz),
      .blink_mask(blink_mask), .an(an), .seg(seg), .dp(dp), .pending(pending),
      .frame_done(frame_done)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   // cyc counts posedges since release; outputs at cyc reflect counter state cyc-1.
   task automatic tick();
      @(negedge clock);
      cyc++;
   endtask

   task automatic goto(input int d, input int s);
      while (((cyc - 1) % 16) != d*4 + s) tick();
   endtask

   task automatic wait_state(input int c);
      while ((cyc % 16) != c) tick();
   endtask

   task automatic to_next_frame();
      tick();
      while ((cyc % 16) != 0) tick();
   endtask

   task automatic test_reset();
      resetN = 1'b0;
      enable = 1'b1;
      repeat (3) @(negedge clock);
      checks++; if (an !== 4'hF) begin errors++; $display("FAIL rst_an got %h want F", an); end
      checks++; if (seg !== 7'h7F) begin errors++; $display("FAIL rst_seg got %h want 7F", seg); end
      checks++; if (dp !== 1'b1) begin errors++; $display("FAIL rst_dp got %b want 1", dp); end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rst_pending got %b want 0", pending); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_fd got %b want 0", frame_done); end
      resetN = 1'b1;
      cyc = 0;
      tick();
      checks++; if (an !== 4'hF) begin errors++; $display("FAIL guard_an got %h want F", an); end
      checks++; if (seg !== 7'h40) begin errors++; $display("FAIL guard_seg got %h want 40", seg); end
      for (int d = 0; d < 4; d++) begin
         goto(d, 1);
         checks++;
         if (an !== ~(4'b0001 << d)) begin
            errors++; $display("FAIL zero_an d%0d got %h want %h", d, an, ~(4'b0001 << d));
         end
         checks++;
         if (seg !== 7'h40 || dp !== 1'b1) begin
            errors++; $display("FAIL zero_seg d%0d got %h/%b want 40/1", d, seg, dp);
         end
      end
   endtask

   task automatic test_hex_load();
      logic [6:0] exp_seg [4];
      logic [3:0] exp_dp;
      exp_seg[0] = 7'h0E; exp_seg[1] = 7'h08; exp_seg[2] = 7'h24; exp_seg[3] = 7'h79;
      exp_dp = 4'b1011;
      value = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL hex_pending got %b want 1", pending); end
      wait_state(15);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL hex_fd got %b want 1", frame_done); end
      to_next_frame();
      for (int d = 0; d < 4; d++) begin
         goto(d, 1);
         checks++;
         if (seg !== exp_seg[d] || dp !== exp_dp[d] || an !== ~(4'b0001 << d)) begin
            errors++;
            $display("FAIL hex d%0d got seg %h dp %b an %h want seg %h dp %b", d, seg, dp, an,
                     exp_seg[d], exp_dp[d]);
         end
      end
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL hex_pending_clr got %b want 0", pending); end
   endtask

   task automatic test_pending();
      wait_state(6);
      value = 16'h1111; dp_in = 4'b0000; load = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (pending !== 1'b1) begin errors++; $display("FAIL pend_set got %b want 1", pending); end
      goto(1, 3);
      checks++; if (seg !== 7'h08) begin errors++; $display("FAIL pend_old_d1 got %h want 08", seg); end
      goto(2, 1);
      checks++; if (seg !== 7'h24 || dp !== 1'b0) begin errors++; $display("FAIL pend_old_d2 got %h/%b want 24/0", seg, dp); end
      goto(3, 1);
      checks++; if (seg !== 7'h79 || pending !== 1'b1) begin errors++; $display("FAIL pend_old_d3 got %h/%b want 79/1", seg, pending); end
      goto(0, 1);
      checks++; if (seg !== 7'h79 || pending !== 1'b0) begin errors++; $display("FAIL pend_new_d0 got %h/%b want 79/0", seg, pending); end
      goto(2, 1);
      checks++; if (seg !== 7'h79 || dp !== 1'b1) begin errors++; $display("FAIL pend_new_d2 got %h/%b want 79/1", seg, dp); end
      wait_state(15);
      checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bnd_fd got %b want 1", frame_done); end
      value = 16'h3333; load = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (pending !== 1'b0) begin errors++; $display("FAIL bnd_pending got %b want 0", pending); end
      goto(0, 1);
      checks++; if (seg !== 7'h30) begin errors++; $display("FAIL bnd_new_d0 got %h want 30", seg); end
   endtask

   task automatic test_octal_lz();
      radix_octal = 1'b1; blank_lz = 1'b1;
      value = 16'h01FF; load = 1'b1;
      tick();
      load = 1'b0;
      to_next_frame();
      for (int d = 0; d < 3; d++) begin
         goto(d, 1);
         checks++;
         if (seg !== 7'h78 || an !== ~(4'b0001 << d)) begin
            errors++; $display("FAIL oct d%0d got seg %h an %h want 78", d, seg, an);
         end
      end
      for (int s = 0; s < 4; s++) begin
         goto(3, s);
         checks++;
         if (an !== 4'hF || seg !== 7'h7F) begin
            errors++; $display("FAIL oct_lz_d3 s%0d got an %h seg %h want F/7F", s, an, seg);
         end
      end
      value = 16'h0000; load = 1'b1;
      tick();
      load = 1'b0;
      to_next_frame();
      goto(0, 1);
      checks++; if (an !== 4'hE || seg !== 7'h40) begin errors++; $display("FAIL lz_d0 got an %h seg %h want E/40", an, seg); end
      for (int d = 1; d < 4; d++) begin
         goto(d, 1);
         checks++;
         if (an !== 4'hF) begin errors++; $display("FAIL lz_d%0d got an %h want F", d, an); end
      end
      radix_octal = 1'b0; blank_lz = 1'b0;
   endtask

   task automatic test_blink_enable();
      int k;
      logic hid;
      blink_mask = 4'b0010;
      to_next_frame();
      for (int f = 0; f < 5; f++) begin
         goto(0, 1);
         checks++; if (an !== 4'hE) begin errors++; $display("FAIL blink_d0 f%0d got an %h want E", f, an); end
         goto(1, 1);
         k = (cyc - 1) / 16;
         hid = ((k / 2) % 2) == 1;
         checks++;
         if (an !== (hid ? 4'hF : 4'hD) || seg !== (hid ? 7'h7F : 7'h40)) begin
            errors++;
            $display("FAIL blink_d1 frame %0d got an %h seg %h want an %h seg %h", k, an, seg,
                     hid ? 4'hF : 4'hD, hid ? 7'h7F : 7'h40);
         end
      end
      blink_mask = 4'b0000;
      enable = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         checks++; if (an !== 4'hF) begin errors++; $display("FAIL disable_an c%0d got %h want F", i, an); end
         tick();
      end
      enable = 1'b1;
   endtask

   task automatic test_async_reset();
      value = 16'h5555; load = 1'b1;
      tick();
      load = 1'b0;
      wait_state(11);
      resetN = 1'b0;
      #1;
      checks++; if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1) begin errors++; $display("FAIL arst_out got an %h seg %h dp %b want F/7F/1", an, seg, dp); end
      checks++; if (pending !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL arst_ctl got %b/%b want 0/0", pending, frame_done); end
      @(negedge clock);
      @(negedge clock);
      resetN = 1'b1;
      cyc = 0;
      tick();
      checks++; if (an !== 4'hF || seg !== 7'h40) begin errors++; $display("FAIL arst_slot0 got an %h seg %h want F/40", an, seg); end
      tick();
      checks++; if (an !== 4'hE || seg !== 7'h40) begin errors++; $display("FAIL arst_slot1 got an %h seg %h want E/40", an, seg); end
      goto(2, 1);
      checks++; if (an !== 4'hB || seg !== 7'h40) begin errors++; $display("FAIL arst_d2 got an %h seg %h want B/40", an, seg); end
   endtask

   initial begin
      test_reset();
      test_hex_load();
      test_pending();
      test_octal_lz();
      test_blink_enable();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
